// File: rtl/signed_fixed_point_divider.sv
// Signed Q-format divider: dividend/divisor with saturation, restoring algorithm, one quotient bit per clock.
// Latency: valid_out N+1 cycles after the accept edge (N = W+F), or 1 cycle for a zero divisor.
// Backpressure: ready_out low from accept until the result cycle completes; start_in while busy is dropped.
module signed_fixed_point_divider #(
    parameter int FIXED_POINT_WIDTH    = 16,
    parameter int FIXED_POINT_POSITION = 10
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start_in,
    input  logic [FIXED_POINT_WIDTH-1:0] dividend_in,
    input  logic [FIXED_POINT_WIDTH-1:0] divisor_in,
    output logic                         ready_out,
    output logic                         valid_out,
    output logic [FIXED_POINT_WIDTH-1:0] quotient_out,
    output logic                         div_by_zero_out
);

    localparam int W     = FIXED_POINT_WIDTH;
    localparam int F     = FIXED_POINT_POSITION;
    localparam int N     = W + F;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [W-1:0]     MAX_VAL  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]     MIN_VAL  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]     ONE_W    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]     MAX_MAG  = {{F{1'b0}}, MAX_VAL};
    localparam logic [N-1:0]     MIN_MAG  = {{F{1'b0}}, MIN_VAL};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIVIDE,
        ST_DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N-1:0]     num_q;      // numerator, shifted out MSB first
    logic [N-1:0]     rem_q;      // partial remainder
    logic [N-1:0]     quo_q;      // quotient magnitude being built
    logic [W-1:0]     dvsr_q;     // |divisor|
    logic             neg_q;      // result sign
    logic             dvd_neg_q;  // dividend sign, picks the divide-by-zero rail
    logic             dz_q;       // divisor was zero
    logic             fin_q;      // all quotient bits done, next DIVIDE cycle forms the result
    logic             ready_q;
    logic             valid_q;
    logic [W-1:0]     quotient_q;
    logic             dbz_q;

    logic [W-1:0]     dvd_mag_d;
    logic [W-1:0]     dvs_mag_d;
    logic             dvs_zero_d;
    logic [N-1:0]     dvsr_ext_d;
    logic [N-1:0]     rem_shift_d;
    logic             ge_d;
    logic [N-1:0]     rem_d;
    logic [N-1:0]     quo_d;
    logic [W-1:0]     result_d;

    // Operand magnitudes; the most negative value maps to 2^(W-1) without overflow
    always_comb begin
        dvd_mag_d  = dividend_in[W-1] ? (~dividend_in + ONE_W) : dividend_in;
        dvs_mag_d  = divisor_in[W-1]  ? (~divisor_in  + ONE_W) : divisor_in;
        dvs_zero_d = (divisor_in == '0);
    end

    // One restoring step: shift in the next numerator bit, subtract if the divisor fits
    always_comb begin
        dvsr_ext_d  = {{F{1'b0}}, dvsr_q};
        rem_shift_d = {rem_q[N-2:0], num_q[N-1]};
        ge_d        = (rem_shift_d >= dvsr_ext_d);
        rem_d       = ge_d ? (rem_shift_d - dvsr_ext_d) : rem_shift_d;
        quo_d       = {quo_q[N-2:0], ge_d};
    end

    // Apply sign and saturate the final magnitude; truncation toward zero falls out of magnitude division
    always_comb begin
        result_d = '0;
        if (dz_q) begin
            result_d = dvd_neg_q ? MIN_VAL : MAX_VAL;
        end else if (!neg_q) begin
            result_d = (quo_q > MAX_MAG) ? MAX_VAL : quo_q[W-1:0];
        end else begin
            result_d = (quo_q > MIN_MAG) ? MIN_VAL : (~quo_q[W-1:0] + ONE_W);
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            num_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            neg_q      <= 1'b0;
            dvd_neg_q  <= 1'b0;
            dz_q       <= 1'b0;
            fin_q      <= 1'b0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            quotient_q <= '0;
            dbz_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    if (start_in) begin
                        num_q     <= {dvd_mag_d, {F{1'b0}}};
                        dvsr_q    <= dvs_mag_d;
                        rem_q     <= '0;
                        quo_q     <= '0;
                        neg_q     <= dividend_in[W-1] ^ divisor_in[W-1];
                        dvd_neg_q <= dividend_in[W-1];
                        dz_q      <= dvs_zero_d;
                        // A zero divisor skips every restoring step and only spends the result cycle
                        fin_q     <= dvs_zero_d;
                        cnt_q     <= CNT_LAST;
                        ready_q   <= 1'b0;
                        state_q   <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    if (fin_q) begin
                        quotient_q <= result_d;
                        dbz_q      <= dz_q;
                        valid_q    <= 1'b1;
                        fin_q      <= 1'b0;
                        state_q    <= ST_DONE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        num_q <= {num_q[N-2:0], 1'b0};
                        if (cnt_q == '0) begin
                            fin_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_out       = ready_q;
    assign valid_out       = valid_q;
    assign quotient_out    = quotient_q;
    assign div_by_zero_out = dbz_q;

endmodule

// File: tb/tb_signed_fixed_point_divider.sv
// Bench for signed_fixed_point_divider: directed vectors, arithmetic reference model, per-cycle compare.
// Latency: checks 27-cycle normal and 1-cycle divide-by-zero result timing.
// Backpressure: checks that start pulses while busy are dropped.
module tb_signed_fixed_point_divider;

    localparam int W   = 16;
    localparam int F   = 10;
    localparam int N   = W + F;
    localparam int LAT = N + 1;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          start_in = 1'b0;
    logic [W-1:0]  dividend_in = '0;
    logic [W-1:0]  divisor_in = '0;
    logic          ready_out;
    logic          valid_out;
    logic [W-1:0]  quotient_out;
    logic          div_by_zero_out;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    int           edge_n = 0;
    bit           pend = 1'b0;
    int           valid_edge = 0;
    int           rdy_edge = 0;
    logic [W-1:0] pend_q = '0;
    logic         pend_dz = 1'b0;
    logic [W-1:0] last_q = '0;
    logic         last_dz = 1'b0;
    bit           exp_valid;

    signed_fixed_point_divider #(
        .FIXED_POINT_WIDTH   (W),
        .FIXED_POINT_POSITION(F)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .dividend_in    (dividend_in),
        .divisor_in     (divisor_in),
        .ready_out      (ready_out),
        .valid_out      (valid_out),
        .quotient_out   (quotient_out),
        .div_by_zero_out(div_by_zero_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference quotient from plain signed arithmetic
    function automatic logic [W-1:0] model_q(input logic [W-1:0] a, input logic [W-1:0] b);
        longint q;
        longint maxv;
        longint minv;
        logic [63:0] qv;
        maxv = (longint'(1) <<< (W - 1)) - 1;
        minv = -(longint'(1) <<< (W - 1));
        if (b == '0) return a[W-1] ? 16'h8000 : 16'h7FFF;
        q = (longint'($signed(a)) * (longint'(1) <<< F)) / longint'($signed(b));
        if (q > maxv) return 16'h7FFF;
        if (q < minv) return 16'h8000;
        qv = q;
        return qv[W-1:0];
    endfunction

    // Model: accept when idle, result due after LAT edges (1 for zero divisor), idle again one edge later
    always @(posedge clk_in) begin
        edge_n++;
        if (!rst_in) begin
            if (!pend && start_in) begin
                pend       = 1'b1;
                valid_edge = edge_n + ((divisor_in == '0) ? 1 : LAT);
                rdy_edge   = valid_edge + 1;
                pend_q     = model_q(dividend_in, divisor_in);
                pend_dz    = (divisor_in == '0);
            end else if (pend && edge_n == rdy_edge) begin
                pend = 1'b0;
            end
        end
    end

    always @(posedge rst_in) begin
        pend    = 1'b0;
        last_q  = '0;
        last_dz = 1'b0;
    end

    // Per-cycle compare against the model
    always @(negedge clk_in) begin
        if (!rst_in) begin
            exp_valid = pend && (edge_n == valid_edge);
            if (exp_valid) begin
                last_q  = pend_q;
                last_dz = pend_dz;
            end
            chk("cmp ready", {31'd0, ready_out}, {31'd0, !pend});
            chk("cmp valid", {31'd0, valid_out}, {31'd0, exp_valid});
            chk("cmp quotient", {16'd0, quotient_out}, {16'd0, last_q});
            chk("cmp dbz", {31'd0, div_by_zero_out}, {31'd0, last_dz});
        end
    end

    // Issue one division from a negedge, check result, latency and ready restore
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic ed, input string nm);
        int n;
        n = 0;
        while (!ready_out && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        start_in    = 1'b1;
        dividend_in = a;
        divisor_in  = b;
        @(posedge clk_in);
        @(negedge clk_in);
        start_in    = 1'b0;
        dividend_in = 16'($urandom);
        divisor_in  = 16'($urandom);
        n = 0;
        while (!valid_out && n < 60) begin
            @(negedge clk_in);
            n++;
        end
        chk({nm, " latency"}, n, (b == '0) ? 1 : LAT);
        chk({nm, " quotient"}, {16'd0, quotient_out}, {16'd0, eq});
        chk({nm, " dbz"}, {31'd0, div_by_zero_out}, {31'd0, ed});
        @(negedge clk_in);
        chk({nm, " valid drop"}, {31'd0, valid_out}, 32'd0);
        chk({nm, " ready back"}, {31'd0, ready_out}, 32'd1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk_in);
        chk("reset ready", {31'd0, ready_out}, 32'd1);
        chk("reset valid", {31'd0, valid_out}, 32'd0);
        chk("reset quotient", {16'd0, quotient_out}, 32'd0);
        chk("reset dbz", {31'd0, div_by_zero_out}, 32'd0);
        rst_in = 1'b0;

        // pin the reference model to hand-computed values
        chk("model 3/2", {16'd0, model_q(16'h0C00, 16'h0800)}, 32'h0600);
        chk("model -1/3", {16'd0, model_q(16'hFFFF, 16'h0003)}, 32'hFEAB);
        chk("model min/-1", {16'd0, model_q(16'h8000, 16'hFC00)}, 32'h7FFF);
        chk("model -1/0", {16'd0, model_q(16'hFC00, 16'h0000)}, 32'h8000);

        @(negedge clk_in);
        run_op(16'h0C00, 16'h0800, 16'h0600, 1'b0, "pos 3/2");
        run_op(16'hF400, 16'h0800, 16'hFA00, 1'b0, "neg -3/2");
        run_op(16'h0001, 16'h0003, 16'h0155, 1'b0, "lsb 1/3");
        run_op(16'hFFFF, 16'h0003, 16'hFEAB, 1'b0, "trunc -1/3");
        run_op(16'hF800, 16'hFC00, 16'h0800, 1'b0, "negneg");
        run_op(16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, "sat max/1");
        run_op(16'h8000, 16'h0001, 16'h8000, 1'b0, "sat min/1");
        run_op(16'h8000, 16'hFC00, 16'h7FFF, 1'b0, "sat min/-1");
        run_op(16'h0400, 16'h0001, 16'h7FFF, 1'b0, "sat 1/lsb");
        run_op(16'h0400, 16'h0000, 16'h7FFF, 1'b1, "dz pos");
        run_op(16'hFC00, 16'h0000, 16'h8000, 1'b1, "dz neg");
        run_op(16'h0000, 16'h0000, 16'h7FFF, 1'b1, "dz zero");
        run_op(16'h0C00, 16'h0800, 16'h0600, 1'b0, "after dz");

        // start pulses while busy and during the result cycle must be dropped
        start_in    = 1'b1;
        dividend_in = 16'h0C00;
        divisor_in  = 16'h0800;
        @(posedge clk_in);
        @(negedge clk_in);
        start_in = 1'b0;
        repeat (5) @(negedge clk_in);
        start_in    = 1'b1;
        dividend_in = 16'h7FFF;
        divisor_in  = 16'h0001;
        @(negedge clk_in);
        start_in = 1'b0;
        n = 0;
        while (!valid_out && n < 60) begin
            @(negedge clk_in);
            n++;
        end
        chk("busy start valid", {31'd0, valid_out}, 32'd1);
        chk("busy start quotient", {16'd0, quotient_out}, 32'h0600);
        start_in    = 1'b1;
        dividend_in = 16'h8000;
        divisor_in  = 16'h0001;
        @(negedge clk_in);
        start_in = 1'b0;
        chk("done start ready", {31'd0, ready_out}, 32'd1);
        @(negedge clk_in);
        chk("done start ignored", {31'd0, ready_out}, 32'd1);

        // asynchronous reset in the middle of a division
        start_in    = 1'b1;
        dividend_in = 16'h0C00;
        divisor_in  = 16'h0800;
        @(posedge clk_in);
        @(negedge clk_in);
        start_in = 1'b0;
        repeat (10) @(negedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        chk("abort ready", {31'd0, ready_out}, 32'd1);
        chk("abort valid", {31'd0, valid_out}, 32'd0);
        chk("abort quotient", {16'd0, quotient_out}, 32'd0);
        chk("abort dbz", {31'd0, div_by_zero_out}, 32'd0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (35) @(negedge clk_in);
        run_op(16'hF400, 16'h0800, 16'hFA00, 1'b0, "post reset");

        repeat (3) @(negedge clk_in);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
